// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped 8-digit seven-segment scanner: CPU-visible registers, per-frame shadow
// copy, one-hot active-low anode multiplexing with tick-0 guard and 16-level PWM.
module seg7_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0010,
  parameter int          TICK_DIV  = 781
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  catodes,
  output logic [7:0]  anodes
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] code);
    case (code)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wr,
                                              input logic [3:0] strb);
    merge_bytes = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge_bytes[b*8 +: 8] = wr[b*8 +: 8];
    end
  endfunction

  logic          ready_r;
  logic [31:0]   rdata_r;
  logic [31:0]   data_r, sdata_r;
  logic [7:0]    dp_r, sdp_r;
  logic          en_r;
  logic [3:0]    bright_r;
  logic [7:0]    mask_r;
  logic          pend_r;
  logic [PW-1:0] presc_r;
  logic [3:0]    tick_r;
  logic [2:0]    digit_r;
  logic [7:0]    frame_r;
  logic [7:0]    anodes_r, catodes_r;

  logic          sel_s, acc_s, wr_s, wr_shadowed_s, copy_s, lit_s;
  logic          presc_wrap_s, tick_wrap_s, digit_wrap_s;
  logic [31:0]   rd_s;
  logic [3:0]    code_s;

  assign sel_s         = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign acc_s         = sel_s && !ready_r;
  assign wr_s          = acc_s && (mem_wstrb != 4'h0);
  assign wr_shadowed_s = wr_s && !mem_addr[3];
  assign presc_wrap_s  = (presc_r == PRESC_MAX);
  assign tick_wrap_s   = presc_wrap_s && (tick_r == 4'hF);
  assign digit_wrap_s  = tick_wrap_s && (digit_r == 3'd7);
  // Shadow reload only at the very first cycle of the digit-0 slot.
  assign copy_s        = en_r && pend_r && (presc_r == '0) && (tick_r == 4'h0) && (digit_r == 3'd0);

  // Register read mux
  always_comb begin
    rd_s = 32'h0;
    case (mem_addr[3:2])
      2'd0:    rd_s = data_r;
      2'd1:    rd_s = {24'h0, dp_r};
      2'd2:    rd_s = {8'h0, mask_r, 4'h0, bright_r, 7'h0, en_r};
      2'd3:    rd_s = {15'h0, pend_r, frame_r, 5'h0, digit_r};
      default: rd_s = 32'h0;
    endcase
  end

  // Lit decision and segment code for the current slot
  always_comb begin
    lit_s  = en_r && mask_r[digit_r] && (tick_r != 4'h0) && (tick_r <= bright_r);
    code_s = sdata_r[{digit_r, 2'b00} +: 4];
  end

  // Bus acknowledge, read data and CPU-visible registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_r  <= 1'b0;
      rdata_r  <= 32'h0;
      data_r   <= 32'h0;
      dp_r     <= 8'h0;
      en_r     <= 1'b0;
      bright_r <= 4'hF;
      mask_r   <= 8'hFF;
    end else begin
      ready_r <= acc_s;
      rdata_r <= acc_s ? rd_s : 32'h0;
      if (wr_s) begin
        case (mem_addr[3:2])
          2'd0: data_r <= merge_bytes(data_r, mem_wdata, mem_wstrb);
          2'd1: if (mem_wstrb[0]) dp_r <= mem_wdata[7:0];
          2'd2: begin
            if (mem_wstrb[0]) en_r     <= mem_wdata[0];
            if (mem_wstrb[1]) bright_r <= mem_wdata[11:8];
            if (mem_wstrb[2]) mask_r   <= mem_wdata[23:16];
          end
          default: ;
        endcase
      end
    end
  end

  // Display shadow and pending flag; a colliding bus write keeps pending set
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sdata_r <= 32'h0;
      sdp_r   <= 8'h0;
      pend_r  <= 1'b0;
    end else begin
      if (copy_s) begin
        sdata_r <= data_r;
        sdp_r   <= dp_r;
      end
      if (wr_shadowed_s)  pend_r <= 1'b1;
      else if (copy_s)    pend_r <= 1'b0;
    end
  end

  // Prescaler, tick, digit and frame counters; held at zero while disabled
  always_ff @(posedge clk) begin
    if (!resetn || !en_r) begin
      presc_r <= '0;
      tick_r  <= 4'h0;
      digit_r <= 3'd0;
      frame_r <= 8'h0;
    end else begin
      presc_r <= presc_wrap_s ? '0 : presc_r + 1'b1;
      if (presc_wrap_s) tick_r  <= tick_r + 4'h1;
      if (tick_wrap_s)  digit_r <= digit_r + 3'd1;
      if (digit_wrap_s) frame_r <= frame_r + 8'h1;
    end
  end

  // Registered anode and segment drivers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      anodes_r  <= 8'hFF;
      catodes_r <= 8'hFF;
    end else if (lit_s) begin
      anodes_r  <= ~(8'h01 << digit_r);
      catodes_r <= {~sdp_r[digit_r], hex7(code_s)};
    end else begin
      anodes_r  <= 8'hFF;
      catodes_r <= 8'hFF;
    end
  end

  assign mem_ready = ready_r;
  assign mem_rdata = rdata_r;
  assign anodes    = anodes_r;
  assign catodes   = catodes_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a time-based reference
// model: scan position is derived from a single cycle count by division.
module tb_seg7_scan_ctrl;
  localparam int          TD    = 4;
  localparam int          FRAME = 128 * TD;
  localparam logic [31:0] BASE  = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  catodes, anodes;

  seg7_scan_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .catodes(catodes), .anodes(anodes)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [31:0] m_data, m_sdata, m_rdata;
  logic [7:0]  m_dp, m_sdp, m_mask, m_an, m_cat;
  logic [3:0]  m_br;
  logic        m_en, m_pend, m_ready;
  int          m_t;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] off);
    case (off[3:2])
      2'd0:    return m_data;
      2'd1:    return {24'h0, m_dp};
      2'd2:    return {8'h0, m_mask, 4'h0, m_br, 7'h0, m_en};
      default: return {15'h0, m_pend, 8'((m_t / FRAME) % 256), 5'h0, 3'((m_t / (16 * TD)) % 8)};
    endcase
  endfunction

  task automatic model_step();
    logic acc, on;
    int tick, dig;
    logic [3:0] code, off;
    if (!resetn) begin
      m_data = 32'h0; m_dp = 8'h0; m_en = 1'b0; m_br = 4'hF; m_mask = 8'hFF;
      m_pend = 1'b0; m_t = 0; m_sdata = 32'h0; m_sdp = 8'h0;
      m_ready = 1'b0; m_rdata = 32'h0; m_an = 8'hFF; m_cat = 8'hFF;
    end else begin
      acc     = mem_valid && (mem_addr[31:4] == BASE[31:4]) && !m_ready;
      off     = mem_addr[3:0];
      m_rdata = acc ? m_read(off) : 32'h0;
      m_ready = acc;
      tick    = (m_t / TD) % 16;
      dig     = (m_t / (16 * TD)) % 8;
      on      = m_en && m_mask[dig] && (tick >= 1) && (tick <= int'(m_br));
      code    = m_sdata[dig*4 +: 4];
      m_an    = on ? ~(8'h01 << dig) : 8'hFF;
      m_cat   = on ? {~m_sdp[dig], hex_tab[code]} : 8'hFF;
      if (m_en && (m_t % FRAME == 0) && m_pend) begin
        m_sdata = m_data;
        m_sdp   = m_dp;
        m_pend  = 1'b0;
      end
      m_t = m_en ? (m_t + 1) % (256 * FRAME) : 0;
      if (acc && mem_wstrb != 4'h0) begin
        case (off[3:2])
          2'd0: begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) m_data[b*8 +: 8] = mem_wdata[b*8 +: 8];
            m_pend = 1'b1;
          end
          2'd1: begin
            if (mem_wstrb[0]) m_dp = mem_wdata[7:0];
            m_pend = 1'b1;
          end
          2'd2: begin
            if (mem_wstrb[0]) m_en   = mem_wdata[0];
            if (mem_wstrb[1]) m_br   = mem_wdata[11:8];
            if (mem_wstrb[2]) m_mask = mem_wdata[23:16];
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_val("ready", {31'h0, mem_ready}, {31'h0, m_ready});
    if (m_ready) check_val("rdata", mem_rdata, m_rdata);
    check_val("anodes", {24'h0, anodes}, {24'h0, m_an});
    check_val("catodes", {24'h0, catodes}, {24'h0, m_cat});
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = st;
    cycle();
    rd = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    cycle();
  endtask

  task automatic wait_an(input logic [7:0] v, input string tag);
    int n = 0;
    while (anodes !== v && n < 3000) begin cycle(); n++; end
    check_val(tag, {24'h0, anodes}, {24'h0, v});
  endtask

  task automatic wait_not(input logic [7:0] v, input string tag);
    int n = 0;
    while (anodes === v && n < 3000) begin cycle(); n++; end
    check_val(tag, {31'h0, anodes !== v}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int c1, n_lit, n_other;

    resetn = 1'b0;
    cycle(); cycle();
    check_val("rst_anodes", {24'h0, anodes}, 32'h0000_00FF);
    check_val("rst_catodes", {24'h0, catodes}, 32'h0000_00FF);
    resetn = 1'b1;
    cycle();
    bus(BASE + 32'h8, 32'h0, 4'h0, rd);
    check_val("ctrl_rst", rd, 32'h00FF_0F00);

    // basic display and timing
    bus(BASE, 32'h8765_43F0, 4'hF, rd);
    bus(BASE + 32'h8, 32'h00FF_0F01, 4'hF, rd);
    wait_not(8'hFE, "wait_dark0");
    wait_an(8'hFE, "wait_d0");
    c1 = cyc;
    check_val("d0_seg", {24'h0, catodes}, 32'h0000_00C0);
    wait_an(8'hFD, "wait_d1");
    check_val("slot_len", cyc - c1, 64);
    check_val("d1_seg", {24'h0, catodes}, 32'h0000_008E);
    wait_an(8'h7F, "wait_d7");
    check_val("d7_seg", {24'h0, catodes}, 32'h0000_0080);
    wait_an(8'hFE, "wait_d0b");
    check_val("frame_len", cyc - c1, FRAME);

    // mid-frame update stays hidden until the next frame
    wait_an(8'hF7, "wait_d3");
    bus(BASE, 32'h1234_5678, 4'hF, rd);
    bus(BASE + 32'hC, 32'h0, 4'h0, rd);
    check_val("pend_set", {31'h0, rd[16]}, 32'h1);
    wait_an(8'hFE, "wait_new");
    check_val("new_d0_seg", {24'h0, catodes}, 32'h0000_0080);
    bus(BASE + 32'hC, 32'h0, 4'h0, rd);
    check_val("pend_clr", {31'h0, rd[16]}, 32'h0);

    // brightness 3, only digit 0 unmasked
    bus(BASE + 32'h8, 32'h0001_0301, 4'hF, rd);
    n_lit = 0; n_other = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (anodes === 8'hFE) n_lit++;
      else if (anodes !== 8'hFF) n_other++;
    end
    check_val("br3_lit", n_lit, 3 * TD);
    check_val("br3_other", n_other, 0);
    bus(BASE + 32'h8, 32'h00FF_0001, 4'hF, rd);
    n_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (anodes !== 8'hFF) n_lit++;
    end
    check_val("br0_dark", n_lit, 0);

    // byte strobe and window edge
    bus(BASE, 32'h0, 4'hF, rd);
    bus(BASE, 32'h0000_AB00, 4'b0010, rd);
    bus(BASE, 32'h0, 4'h0, rd);
    check_val("byte_wr", rd, 32'h0000_AB00);
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wstrb = 4'h0;
    cycle(); cycle();
    check_val("oow_ready", {31'h0, mem_ready}, 32'h0);
    mem_valid = 1'b0;
    cycle();

    // reset during digit-5 slot with a read outstanding
    bus(BASE + 32'h8, 32'h00FF_0F01, 4'hF, rd);
    wait_an(8'hDF, "wait_d5");
    mem_valid = 1'b1; mem_addr = BASE + 32'h8; resetn = 1'b0;
    cycle();
    check_val("rst_noack", {31'h0, mem_ready}, 32'h0);
    resetn = 1'b1; mem_valid = 1'b0;
    cycle();
    bus(BASE + 32'hC, 32'h0, 4'h0, rd);
    check_val("status_rst", rd, 32'h0);
    bus(BASE + 32'h8, 32'h0, 4'h0, rd);
    check_val("ctrl_rst2", rd, 32'h00FF_0F00);
    bus(BASE, 32'h0, 4'h0, rd);
    check_val("data_rst", rd, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] a, w;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        resetn = 1'b0; cycle(); resetn = 1'b1;
      end else if (r < 60) begin
        a = BASE + ($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) a = (($urandom_range(0, 1) == 1) ? BASE + 32'h10 : BASE - 32'h4);
        w = $urandom;
        if (a[3:2] == 2'd2) w[0] = ($urandom_range(0, 7) != 0);
        bus(a, w, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), w);
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
